// File: rtl/data_memory_arbiter.sv
// N-port valid/ready arbiter and byte-lane controller for a single-port word SRAM.
// One access per three cycles: grant/latch, RAM access, response formatting.
module data_memory_arbiter #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 11,
  parameter int NUM_PORTS      = 2,
  parameter int PRIORITY_MODE  = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            port_enable,
  input  logic [NUM_PORTS-1:0]            req_valid,
  output logic [NUM_PORTS-1:0]            req_ready,
  input  logic [NUM_PORTS-1:0]            req_wr_en,
  input  logic [NUM_PORTS-1:0]            req_unsigned,
  input  logic [2*NUM_PORTS-1:0]          req_data_length,
  input  logic [DATA_LENGTH*NUM_PORTS-1:0] req_address,
  input  logic [DATA_LENGTH*NUM_PORTS-1:0] req_data_in,
  output logic [NUM_PORTS-1:0]            rsp_valid,
  output logic                            rsp_error,
  output logic [DATA_LENGTH-1:0]          rsp_data,
  output logic                            mem_en,
  output logic [3:0]                      mem_we,
  output logic [ADDRESS_LENGTH-1:0]       mem_address,
  output logic [DATA_LENGTH-1:0]          mem_data_in,
  input  logic [DATA_LENGTH-1:0]          mem_data_out
);
  localparam int DL = DATA_LENGTH;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t        state_reg;
  logic [PW-1:0] ptr_reg, port_reg;
  logic          wr_reg, uns_reg, err_reg;
  logic [1:0]    len_reg, off_reg;

  logic [DL-1:0] addr_arr [NUM_PORTS];
  logic [DL-1:0] data_arr [NUM_PORTS];
  logic [1:0]    len_arr  [NUM_PORTS];
  logic [NUM_PORTS-1:0] unused_addr;

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign addr_arr[gi]    = req_address[gi*DL +: DL];
      assign data_arr[gi]    = req_data_in[gi*DL +: DL];
      assign len_arr[gi]     = req_data_length[2*gi +: 2];
      assign unused_addr[gi] = ^addr_arr[gi][DL-1:ADDRESS_LENGTH+2];
    end
  endgenerate

  logic [NUM_PORTS-1:0] eligible;
  logic                 grant_found;
  logic [PW-1:0]        grant_idx;

  assign eligible = req_valid & port_enable;

  // Round-robin starts the search at ptr_reg; fixed priority always starts at port 0.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = (PRIORITY_MODE == 1) ? k : (int'(ptr_reg) + k) % NUM_PORTS;
      if (!grant_found && eligible[idx]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      req_ready[k] = rst_n && (state_reg == IDLE) && grant_found && (grant_idx == PW'(k));
  end

  logic [DL-1:0] g_addr, g_data, g_wdata;
  logic [1:0]    g_len;
  logic          g_err;
  logic [3:0]    g_we;

  always_comb begin
    g_addr = addr_arr[grant_idx];
    g_data = data_arr[grant_idx];
    g_len  = len_arr[grant_idx];
    g_err  = (g_len == 2'b11) || (g_len == 2'b01 && g_addr[0]) ||
             (g_len == 2'b10 && g_addr[1:0] != 2'b00);
    case (g_len)
      2'b00:   begin g_we = 4'b0001 << g_addr[1:0]; g_wdata = {4{g_data[7:0]}};  end
      2'b01:   begin g_we = 4'b0011 << g_addr[1:0]; g_wdata = {2{g_data[15:0]}}; end
      default: begin g_we = 4'b1111;                g_wdata = g_data;            end
    endcase
    if (!req_wr_en[grant_idx] || g_err) g_we = 4'b0000;
  end

  logic [DL-1:0] shifted, load_data;

  always_comb begin
    shifted = mem_data_out >> {off_reg, 3'b000};
    case (len_reg)
      2'b00:   load_data = uns_reg ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = uns_reg ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      port_reg    <= '0;
      wr_reg      <= 1'b0;
      uns_reg     <= 1'b0;
      err_reg     <= 1'b0;
      len_reg     <= 2'b00;
      off_reg     <= 2'b00;
      rsp_valid   <= '0;
      rsp_error   <= 1'b0;
      rsp_data    <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 4'b0000;
      mem_address <= '0;
      mem_data_in <= '0;
    end else begin
      rsp_valid <= '0;
      rsp_error <= 1'b0;
      case (state_reg)
        IDLE: if (grant_found) begin
          port_reg    <= grant_idx;
          wr_reg      <= req_wr_en[grant_idx];
          uns_reg     <= req_unsigned[grant_idx];
          len_reg     <= g_len;
          off_reg     <= g_addr[1:0];
          err_reg     <= g_err;
          mem_en      <= !g_err;
          mem_we      <= g_we;
          mem_address <= g_addr[ADDRESS_LENGTH+1:2];
          mem_data_in <= g_wdata;
          if (PRIORITY_MODE == 0)
            ptr_reg <= (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
          state_reg   <= ACCESS;
        end
        ACCESS: begin
          mem_en    <= 1'b0;
          mem_we    <= 4'b0000;
          state_reg <= RESPOND;
        end
        RESPOND: begin
          rsp_data            <= (wr_reg || err_reg) ? '0 : load_data;
          rsp_valid[port_reg] <= 1'b1;
          rsp_error           <= err_reg;
          state_reg           <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench: drivers push expected responses, a negedge monitor pops and compares.
// A second fixed-priority instance shares the request inputs to observe starvation.
module tb_data_memory_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  port_enable, req_valid, req_wr_en, req_unsigned;
  logic [3:0]  req_data_length;
  logic [63:0] req_address, req_data_in;
  logic [1:0]  req_ready, rsp_valid, f_req_ready, f_rsp_valid;
  logic        rsp_error, mem_en, f_rsp_error, f_mem_en;
  logic [31:0] rsp_data, mem_data_in, mem_data_out, f_rsp_data, f_mem_data_in;
  logic [3:0]  mem_we, f_mem_we;
  logic [10:0] mem_address, f_mem_address;

  always #5 clk = ~clk;

  data_memory_arbiter #(.PRIORITY_MODE(0)) dut (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable), .req_valid(req_valid),
    .req_ready(req_ready), .req_wr_en(req_wr_en), .req_unsigned(req_unsigned),
    .req_data_length(req_data_length), .req_address(req_address), .req_data_in(req_data_in),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data), .mem_en(mem_en),
    .mem_we(mem_we), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out));

  data_memory_arbiter #(.PRIORITY_MODE(1)) u_fix (
    .clk(clk), .rst_n(rst_n), .port_enable(port_enable), .req_valid(req_valid),
    .req_ready(f_req_ready), .req_wr_en(req_wr_en), .req_unsigned(req_unsigned),
    .req_data_length(req_data_length), .req_address(req_address), .req_data_in(req_data_in),
    .rsp_valid(f_rsp_valid), .rsp_error(f_rsp_error), .rsp_data(f_rsp_data), .mem_en(f_mem_en),
    .mem_we(f_mem_we), .mem_address(f_mem_address), .mem_data_in(f_mem_data_in),
    .mem_data_out(32'h0));

  // Byte-writable RAM with registered read, as the macro behaves.
  logic [31:0] ram [0:2047];
  logic [31:0] ram_q = 32'h0;
  assign mem_data_out = ram_q;
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_address][b*8 +: 8] <= mem_data_in[b*8 +: 8];
      ram_q <= ram[mem_address];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    bit          err;
    logic [31:0] data;
    int          at;
  } exp_t;
  exp_t q[$];
  exp_t e;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid != 2'b00) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", rsp_valid);
      end else begin
        e = q.pop_front();
        $display("rsp port=%0d err=%0b data=%h cycle=%0d", e.port, rsp_error, rsp_data, cyc);
        check("rsp_valid", 32'(rsp_valid), 32'(1) << e.port);
        check("rsp_error", 32'(rsp_error), 32'(e.err));
        check("rsp_data", rsp_data, e.data);
        check("rsp_latency", cyc, e.at);
      end
    end
  end

  task automatic set_port(input int p, input bit wr, input bit uns, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] din);
    req_wr_en[p]             = wr;
    req_unsigned[p]          = uns;
    req_data_length[2*p +: 2] = len;
    req_address[32*p +: 32]  = addr;
    req_data_in[32*p +: 32]  = din;
    req_valid[p]             = 1'b1;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the response cycle.
  task automatic issue(input int p, input bit wr, input bit uns, input logic [1:0] len,
                       input logic [31:0] addr, input logic [31:0] din, input bit exp_err,
                       input logic [31:0] exp_data, input logic [3:0] exp_we,
                       input logic [31:0] exp_mdin, output int waited);
    exp_t x;
    set_port(p, wr, uns, len, addr, din);
    waited = 0;
    #1;
    while (!req_ready[p] && waited < 20) begin
      waited++;
      @(negedge clk);
      #1;
    end
    if (!req_ready[p]) begin
      check("handshake_timeout", 32'(req_ready), 32'(1) << p);
      req_valid[p] = 1'b0;
      return;
    end
    $display("req port=%0d wr=%0b uns=%0b len=%b addr=%h din=%h", p, wr, uns, len, addr, din);
    x.port = p; x.err = exp_err; x.data = exp_data; x.at = cyc + 3;
    q.push_back(x);
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
    @(negedge clk);
    check("access_mem_en", 32'(mem_en), 32'(!exp_err));
    if (!exp_err) begin
      check("access_mem_we", 32'(mem_we), 32'(exp_we));
      check("access_mem_address", 32'(mem_address), 32'(addr[12:2]));
      if (wr) check("access_mem_data_in", mem_data_in, exp_mdin);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "watchdog");
  end

  int w, grants;
  exp_t x;
  logic [1:0] want;

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    rst_n = 1'b0;
    port_enable = 2'b11; req_valid = 2'b00; req_wr_en = 2'b00; req_unsigned = 2'b00;
    req_data_length = 4'h0; req_address = 64'h0; req_data_in = 64'h0;
    repeat (2) @(negedge clk);
    check("reset_mem_en", 32'(mem_en), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_req_ready", 32'(req_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word store/load round trip
    issue(0, 1, 0, 2'b10, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF, w);
    issue(0, 0, 0, 2'b10, 32'h10, 32'h0, 0, 32'hDEADBEEF, 4'b0000, 32'h0, w);
    // Byte lane and extension; word @4 becomes A5ADBEEF
    issue(0, 1, 0, 2'b00, 32'h13, 32'h000000A5, 0, 32'h0, 4'b1000, 32'hA5A5A5A5, w);
    issue(0, 0, 0, 2'b00, 32'h13, 32'h0, 0, 32'hFFFFFFA5, 4'b0000, 32'h0, w);
    issue(0, 0, 1, 2'b00, 32'h13, 32'h0, 0, 32'h000000A5, 4'b0000, 32'h0, w);
    issue(0, 0, 0, 2'b01, 32'h12, 32'h0, 0, 32'hFFFFA5AD, 4'b0000, 32'h0, w);
    issue(1, 1, 0, 2'b01, 32'h22, 32'h00001234, 0, 32'h0, 4'b1100, 32'h12341234, w);
    issue(1, 0, 0, 2'b10, 32'h20, 32'h0, 0, 32'h12340000, 4'b0000, 32'h0, w);
    // Errors: misaligned half, reserved length (last grant port 1 -> pointer 0)
    issue(0, 0, 0, 2'b01, 32'h11, 32'h0, 1, 32'h0, 4'b0000, 32'h0, w);
    issue(1, 0, 0, 2'b11, 32'h00, 32'h0, 1, 32'h0, 4'b0000, 32'h0, w);

    // Both ports valid continuously
    set_port(0, 0, 0, 2'b10, 32'h10, 32'h0);
    set_port(1, 0, 0, 2'b10, 32'h20, 32'h0);
    grants = 0;
    for (int c = 0; c < 40 && grants < 4; c++) begin
      #1;
      if (f_req_ready != 2'b00) check("fixed_grant", 32'(f_req_ready), 32'h1);
      if (req_ready != 2'b00) begin
        want = 2'b01 << (grants % 2);
        check("rr_grant", 32'(req_ready), 32'(want));
        x.port = grants % 2; x.err = 0;
        x.data = (grants % 2 == 1) ? 32'h12340000 : 32'hA5ADBEEF;
        x.at = cyc + 3;
        q.push_back(x);
        $display("grant rr=%b fixed=%b cycle=%0d", req_ready, f_req_ready, cyc);
        grants++;
        if (grants == 4) begin
          @(posedge clk);
          #1 req_valid = 2'b00;
        end
      end
      @(negedge clk);
    end
    check("rr_grant_count", grants, 4);
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    // Disabled port is never granted, then granted immediately once enabled
    port_enable = 2'b01;
    set_port(1, 0, 0, 2'b10, 32'h20, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("disabled_ready", 32'(req_ready[1]), 32'h0);
      check("disabled_ready_fixed", 32'(f_req_ready[1]), 32'h0);
      @(negedge clk);
    end
    port_enable = 2'b11;
    issue(1, 0, 0, 2'b10, 32'h20, 32'h0, 0, 32'h12340000, 4'b0000, 32'h0, w);
    check("reenable_wait", w, 0);

    // Reset during ACCESS: outputs clear, no response, pointer returns to 0
    set_port(0, 1, 0, 2'b10, 32'h30, 32'h11111111);
    #1;
    check("t5_grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    check("t5_access_en", 32'(mem_en), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_req_ready", 32'(req_ready), 32'h0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_rsp_error", 32'(rsp_error), 32'h0);
    check("t5_rsp_data", rsp_data, 32'h0);
    check("t5_mem_en", 32'(mem_en), 32'h0);
    check("t5_mem_we", 32'(mem_we), 32'h0);
    check("t5_mem_address", 32'(mem_address), 32'h0);
    check("t5_mem_data_in", mem_data_in, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    set_port(0, 0, 0, 2'b10, 32'h10, 32'h0);
    set_port(1, 0, 0, 2'b10, 32'h20, 32'h0);
    #1;
    check("t5_ptr_reset_grant", 32'(req_ready), 32'h1);
    if (req_ready != 2'b00) begin
      x.port = req_ready[1] ? 1 : 0; x.err = 0;
      x.data = req_ready[1] ? 32'h12340000 : 32'hA5ADBEEF;
      x.at = cyc + 3;
      q.push_back(x);
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (5) @(negedge clk);

    check("scoreboard_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
